// File: rtl/mmu_xlate_arbiter.sv
// mmu_xlate_arbiter: shares one TLB lookup port between the instruction-fetch
// and data-memory translation requesters. Unmapped segments and user-mode
// kernel-address errors are answered locally in one cycle; mapped segments are
// arbitrated round-robin and sequenced through a request/response TLB lookup.
module mmu_xlate_arbiter #(
    parameter bit WITH_TLB = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        user_mode,
    input  logic        kseg0_uncached,
    input  logic [7:0]  asid,
    input  logic        tlb_busy,
    input  logic        i_req,
    input  logic [31:0] i_vaddr,
    output logic        i_ack,
    output logic [31:0] i_paddr,
    output logic        i_uncached,
    output logic        i_refill,
    output logic        i_invalid,
    output logic        i_addr_err,
    input  logic        d_req,
    input  logic [31:0] d_vaddr,
    input  logic        d_we,
    output logic        d_ack,
    output logic [31:0] d_paddr,
    output logic        d_uncached,
    output logic        d_refill,
    output logic        d_invalid,
    output logic        d_modified,
    output logic        d_addr_err,
    output logic        tlb_req,
    output logic [18:0] tlb_vpn2,
    output logic        tlb_odd,
    output logic [7:0]  tlb_asid,
    input  logic        tlb_rsp_valid,
    input  logic        tlb_hit,
    input  logic [19:0] tlb_pfn,
    input  logic        tlb_v,
    input  logic        tlb_d,
    input  logic [2:0]  tlb_c
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t      state;
    logic        gnt_d;      // 1 = the lookup in flight belongs to D
    logic        rr_d;       // 1 = D won the most recent tie
    logic        cap_we;
    logic [11:0] cap_off;
    logic        cap_hit;
    logic [19:0] cap_pfn;
    logic        cap_v;
    logic        cap_dirty;
    logic [2:0]  cap_c;

    // Local translation for errors, kseg0/kseg1 and (without a TLB) mapped
    // segments. Result is {uncached, paddr}; an address error yields all zeros.
    function automatic logic [32:0] bypass_xlate(input logic [31:0] vaddr,
                                                 input logic        err,
                                                 input logic        k0_unc);
        logic [32:0] r;
        r = {1'b0, vaddr};
        if (err)
            r = '0;
        else if (vaddr[31:29] == 3'b100)
            r = {k0_unc, 3'b000, vaddr[28:0]};
        else if (vaddr[31:29] == 3'b101)
            r = {1'b1, 3'b000, vaddr[28:0]};
        return r;
    endfunction

    // Requester classification; the ack cycle belongs to the finished
    // transaction, so a request is only sampled while ack is low.
    logic i_err, i_kseg, i_mapped, i_sample, i_bypass, i_pend;
    logic d_err, d_kseg, d_mapped, d_sample, d_bypass, d_pend;
    logic [32:0] i_byp_res, d_byp_res;

    assign i_err     = user_mode & i_vaddr[31];
    assign i_kseg    = (i_vaddr[31:30] == 2'b10);
    assign i_mapped  = ~i_err & ~i_kseg;
    assign i_sample  = i_req & ~i_ack;
    assign i_bypass  = i_sample & (i_err | i_kseg | (i_mapped & ~WITH_TLB));
    assign i_pend    = i_sample & i_mapped & WITH_TLB;
    assign i_byp_res = bypass_xlate(i_vaddr, i_err, kseg0_uncached);

    assign d_err     = user_mode & d_vaddr[31];
    assign d_kseg    = (d_vaddr[31:30] == 2'b10);
    assign d_mapped  = ~d_err & ~d_kseg;
    assign d_sample  = d_req & ~d_ack;
    assign d_bypass  = d_sample & (d_err | d_kseg | (d_mapped & ~WITH_TLB));
    assign d_pend    = d_sample & d_mapped & WITH_TLB;
    assign d_byp_res = bypass_xlate(d_vaddr, d_err, kseg0_uncached);

    // Grant selection: on a tie the requester that did not win the last tie goes.
    logic        grant, pick_d;
    logic [31:0] g_vaddr;

    assign pick_d  = d_pend & (~i_pend | ~rr_d);
    assign grant   = (state == IDLE) & ~tlb_busy & (i_pend | d_pend);
    assign g_vaddr = pick_d ? d_vaddr : i_vaddr;

    // Decoded TLB result, presented to the granted requester from RESP.
    logic [31:0] tlb_paddr;
    logic        tlb_unc, tlb_refill, tlb_inval, tlb_modif;

    assign tlb_paddr  = {cap_pfn, cap_off};
    assign tlb_unc    = (cap_c == 3'b010);
    assign tlb_refill = ~cap_hit;
    assign tlb_inval  = cap_hit & ~cap_v;
    assign tlb_modif  = cap_hit & cap_v & cap_we & ~cap_dirty;

    // Lookup sequencer: grant, one-cycle strobe, wait for the result, respond.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            gnt_d     <= 1'b0;
            rr_d      <= 1'b0;
            cap_we    <= 1'b0;
            cap_off   <= '0;
            cap_hit   <= 1'b0;
            cap_pfn   <= '0;
            cap_v     <= 1'b0;
            cap_dirty <= 1'b0;
            cap_c     <= '0;
            tlb_req   <= 1'b0;
            tlb_vpn2  <= '0;
            tlb_odd   <= 1'b0;
            tlb_asid  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant) begin
                        if (i_pend && d_pend)
                            rr_d <= pick_d;
                        gnt_d    <= pick_d;
                        cap_we   <= pick_d & d_we;
                        cap_off  <= g_vaddr[11:0];
                        tlb_vpn2 <= g_vaddr[31:13];
                        tlb_odd  <= g_vaddr[12];
                        tlb_asid <= asid;
                        tlb_req  <= 1'b1;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    tlb_req <= 1'b0;
                    state   <= WAIT;
                end
                WAIT: begin
                    if (tlb_rsp_valid) begin
                        cap_hit   <= tlb_hit;
                        cap_pfn   <= tlb_pfn;
                        cap_v     <= tlb_v;
                        cap_dirty <= tlb_d;
                        cap_c     <= tlb_c;
                        state     <= RESP;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // I result registers: local answer one cycle after sampling, else TLB result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_ack      <= 1'b0;
            i_paddr    <= '0;
            i_uncached <= 1'b0;
            i_refill   <= 1'b0;
            i_invalid  <= 1'b0;
            i_addr_err <= 1'b0;
        end else begin
            i_ack <= 1'b0;
            if (i_bypass) begin
                i_ack      <= 1'b1;
                i_paddr    <= i_byp_res[31:0];
                i_uncached <= i_byp_res[32];
                i_refill   <= 1'b0;
                i_invalid  <= 1'b0;
                i_addr_err <= i_err;
            end else if (state == RESP && !gnt_d) begin
                i_ack      <= 1'b1;
                i_paddr    <= tlb_paddr;
                i_uncached <= tlb_unc;
                i_refill   <= tlb_refill;
                i_invalid  <= tlb_inval;
                i_addr_err <= 1'b0;
            end
        end
    end

    // D result registers: same as I plus the store-to-clean-page flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_ack      <= 1'b0;
            d_paddr    <= '0;
            d_uncached <= 1'b0;
            d_refill   <= 1'b0;
            d_invalid  <= 1'b0;
            d_modified <= 1'b0;
            d_addr_err <= 1'b0;
        end else begin
            d_ack <= 1'b0;
            if (d_bypass) begin
                d_ack      <= 1'b1;
                d_paddr    <= d_byp_res[31:0];
                d_uncached <= d_byp_res[32];
                d_refill   <= 1'b0;
                d_invalid  <= 1'b0;
                d_modified <= 1'b0;
                d_addr_err <= d_err;
            end else if (state == RESP && gnt_d) begin
                d_ack      <= 1'b1;
                d_paddr    <= tlb_paddr;
                d_uncached <= tlb_unc;
                d_refill   <= tlb_refill;
                d_invalid  <= tlb_inval;
                d_modified <= tlb_modif;
                d_addr_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mmu_xlate_arbiter.sv
// Directed bench for mmu_xlate_arbiter: a vector table covering local and TLB
// translations, plus hand sequences for arbitration, tlb_busy and reset.
module tb_mmu_xlate_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        user_mode, kseg0_uncached;
    logic [7:0]  asid;
    logic        tlb_busy;
    logic        i_req;
    logic [31:0] i_vaddr;
    logic        i_ack, i_uncached, i_refill, i_invalid, i_addr_err;
    logic [31:0] i_paddr;
    logic        d_req, d_we;
    logic [31:0] d_vaddr;
    logic        d_ack, d_uncached, d_refill, d_invalid, d_modified, d_addr_err;
    logic [31:0] d_paddr;
    logic        tlb_req, tlb_odd;
    logic [18:0] tlb_vpn2;
    logic [7:0]  tlb_asid;
    logic        tlb_rsp_valid, tlb_hit, tlb_v, tlb_d;
    logic [19:0] tlb_pfn;
    logic [2:0]  tlb_c;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mmu_xlate_arbiter #(.WITH_TLB(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .user_mode(user_mode), .kseg0_uncached(kseg0_uncached),
        .asid(asid), .tlb_busy(tlb_busy),
        .i_req(i_req), .i_vaddr(i_vaddr), .i_ack(i_ack), .i_paddr(i_paddr),
        .i_uncached(i_uncached), .i_refill(i_refill), .i_invalid(i_invalid), .i_addr_err(i_addr_err),
        .d_req(d_req), .d_vaddr(d_vaddr), .d_we(d_we), .d_ack(d_ack), .d_paddr(d_paddr),
        .d_uncached(d_uncached), .d_refill(d_refill), .d_invalid(d_invalid),
        .d_modified(d_modified), .d_addr_err(d_addr_err),
        .tlb_req(tlb_req), .tlb_vpn2(tlb_vpn2), .tlb_odd(tlb_odd), .tlb_asid(tlb_asid),
        .tlb_rsp_valid(tlb_rsp_valid), .tlb_hit(tlb_hit), .tlb_pfn(tlb_pfn),
        .tlb_v(tlb_v), .tlb_d(tlb_d), .tlb_c(tlb_c)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        bit          d;      // 1 = D port, 0 = I port
        bit          um;
        bit          k0u;
        logic [31:0] va;
        bit          we;
        bit          map;    // expect a TLB lookup
        bit          hit;
        logic [19:0] pfn;
        bit          v;
        bit          dt;
        logic [2:0]  c;
        logic [31:0] pa;
        bit          unc;
        bit          refill;
        bit          inval;
        bit          modif;
        bit          aerr;
    } vec_t;

    vec_t vt[11];

    // Apply one table entry on its port, play the TLB if a lookup is issued,
    // and compare the result seen during the ack cycle.
    task automatic run_vec(input int idx, input vec_t v);
        bit   seen_req, got_ack, resp_next, ack;
        int   cyc;
        logic [7:0] a;
        a = 8'(idx * 17 + 3);
        user_mode      = v.um;
        kseg0_uncached = v.k0u;
        asid           = a;
        if (v.d) begin
            d_req = 1'b1; d_vaddr = v.va; d_we = v.we;
        end else begin
            i_req = 1'b1; i_vaddr = v.va;
        end
        seen_req = 0; got_ack = 0; resp_next = 0;
        for (cyc = 1; cyc <= 20 && !got_ack; cyc++) begin
            @(negedge clk);
            tlb_rsp_valid = 1'b0;
            if (resp_next) begin
                tlb_rsp_valid = 1'b1;
                tlb_hit = v.hit; tlb_pfn = v.pfn; tlb_v = v.v; tlb_d = v.dt; tlb_c = v.c;
                resp_next = 0;
            end
            if (tlb_req && !seen_req) begin
                seen_req = 1;
                resp_next = 1;
                chk($sformatf("v%0d vpn2", idx), 64'(tlb_vpn2), 64'(v.va[31:13]));
                chk($sformatf("v%0d odd", idx), 64'(tlb_odd), 64'(v.va[12]));
                chk($sformatf("v%0d asid", idx), 64'(tlb_asid), 64'(a));
            end
            ack = v.d ? d_ack : i_ack;
            if (ack) begin
                got_ack = 1;
                if (!v.map) chk($sformatf("v%0d latency", idx), 64'(cyc), 64'd1);
                if (v.d) begin
                    chk($sformatf("v%0d d_paddr", idx), 64'(d_paddr), 64'(v.pa));
                    chk($sformatf("v%0d d_flags", idx),
                        64'({d_uncached, d_refill, d_invalid, d_modified, d_addr_err}),
                        64'({v.unc, v.refill, v.inval, v.modif, v.aerr}));
                    d_req = 1'b0;
                end else begin
                    chk($sformatf("v%0d i_paddr", idx), 64'(i_paddr), 64'(v.pa));
                    chk($sformatf("v%0d i_flags", idx),
                        64'({i_uncached, i_refill, i_invalid, i_addr_err}),
                        64'({v.unc, v.refill, v.inval, v.aerr}));
                    i_req = 1'b0;
                end
            end
        end
        if (!got_ack) begin
            chk($sformatf("v%0d ack timeout", idx), 64'd0, 64'd1);
            i_req = 1'b0; d_req = 1'b0;
        end
        chk($sformatf("v%0d tlb_req used", idx), 64'(seen_req), 64'(v.map));
        @(negedge clk);
        tlb_rsp_valid = 1'b0;
        user_mode = 1'b0;
    endtask

    // Serve one pending mapped lookup with a clean hit and report which port acked.
    task automatic serve(input string nm, input logic [18:0] exp_vpn2, input bit exp_d);
        bit seen, got, resp_next;
        seen = 0; got = 0; resp_next = 0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            tlb_rsp_valid = 1'b0;
            if (resp_next) begin
                tlb_rsp_valid = 1'b1;
                tlb_hit = 1'b1; tlb_pfn = 20'h11111; tlb_v = 1'b1; tlb_d = 1'b1; tlb_c = 3'd3;
                resp_next = 0;
            end
            if (tlb_req && !seen) begin
                seen = 1;
                resp_next = 1;
                chk({nm, " vpn2"}, 64'(tlb_vpn2), 64'(exp_vpn2));
            end
            if (i_ack || d_ack) begin
                got = 1;
                chk({nm, " acking port"}, 64'({i_ack, d_ack}), exp_d ? 64'b01 : 64'b10);
                if (d_ack) d_req = 1'b0;
                if (i_ack) i_req = 1'b0;
            end
        end
        if (!got) begin
            chk({nm, " timeout"}, 64'd0, 64'd1);
            i_req = 1'b0; d_req = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bit seen, bad;
        //        d  um k0u va            we map hit pfn       v  dt c     pa            unc rf inv mod aer
        vt[0]  = '{1, 0, 1, 32'hA0001234, 0, 0, 0, 20'h0,     0, 0, 3'd0, 32'h00001234, 1, 0, 0, 0, 0};
        vt[1]  = '{0, 0, 0, 32'h80400000, 0, 0, 0, 20'h0,     0, 0, 3'd0, 32'h00400000, 0, 0, 0, 0, 0};
        vt[2]  = '{0, 0, 1, 32'h9FFFFFFC, 0, 0, 0, 20'h0,     0, 0, 3'd0, 32'h1FFFFFFC, 1, 0, 0, 0, 0};
        vt[3]  = '{1, 1, 0, 32'h80000000, 0, 0, 0, 20'h0,     0, 0, 3'd0, 32'h00000000, 0, 0, 0, 0, 1};
        vt[4]  = '{0, 1, 1, 32'hC0000000, 0, 0, 0, 20'h0,     0, 0, 3'd0, 32'h00000000, 0, 0, 0, 0, 1};
        vt[5]  = '{0, 0, 0, 32'h00403ABC, 0, 1, 1, 20'h12345, 1, 0, 3'd3, 32'h12345ABC, 0, 0, 0, 0, 0};
        vt[6]  = '{1, 0, 0, 32'h00002000, 1, 1, 1, 20'hABCDE, 1, 0, 3'd2, 32'hABCDE000, 1, 0, 0, 1, 0};
        vt[7]  = '{1, 0, 0, 32'h7FFFF123, 0, 1, 0, 20'h00001, 1, 1, 3'd0, 32'h00001123, 0, 1, 0, 0, 0};
        vt[8]  = '{1, 0, 0, 32'hC0001FFF, 0, 1, 1, 20'h00042, 0, 1, 3'd3, 32'h00042FFF, 0, 0, 1, 0, 0};
        vt[9]  = '{1, 0, 0, 32'hE0000004, 1, 1, 1, 20'hFFFFF, 1, 1, 3'd2, 32'hFFFFF004, 1, 0, 0, 0, 0};
        vt[10] = '{0, 1, 0, 32'h00001000, 0, 1, 1, 20'h00010, 1, 0, 3'd3, 32'h00010000, 0, 0, 0, 0, 0};

        rst_n = 1'b0; user_mode = 1'b0; kseg0_uncached = 1'b0; asid = '0; tlb_busy = 1'b0;
        i_req = 1'b0; i_vaddr = '0; d_req = 1'b0; d_vaddr = '0; d_we = 1'b0;
        tlb_rsp_valid = 1'b0; tlb_hit = 1'b0; tlb_pfn = '0; tlb_v = 1'b0; tlb_d = 1'b0; tlb_c = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset acks", 64'({i_ack, d_ack, tlb_req}), 64'd0);
        chk("reset paddrs", 64'({i_paddr, d_paddr}), 64'd0);
        chk("reset tlb fields", 64'({tlb_vpn2, tlb_odd, tlb_asid}), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int k = 0; k < 11; k++) run_vec(k, vt[k]);

        // Contention: D wins the first tie after reset, I the next tie
        do_reset();
        i_req = 1'b1; i_vaddr = 32'h00001000;
        d_req = 1'b1; d_vaddr = 32'h00002000; d_we = 1'b0;
        serve("tie1 first", 19'h00001, 1'b1);
        serve("tie1 second", 19'h00000, 1'b0);
        @(negedge clk);
        i_req = 1'b1; d_req = 1'b1;
        serve("tie2 first", 19'h00000, 1'b0);
        serve("tie2 second", 19'h00001, 1'b1);
        @(negedge clk);

        // tlb_busy holds off the grant; the kseg1 request on D still acks in one cycle
        tlb_busy = 1'b1;
        i_req = 1'b1; i_vaddr = 32'h00005000;
        d_req = 1'b1; d_vaddr = 32'hA0000010;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (tlb_req) seen = 1;
            if (c == 0) begin
                chk("busy d_ack", 64'(d_ack), 64'd1);
                chk("busy d_paddr", 64'(d_paddr), 64'h00000010);
                d_req = 1'b0;
            end
        end
        chk("busy no tlb_req", 64'(seen), 64'd0);
        tlb_busy = 1'b0;
        serve("busy release", 19'h00002, 1'b0);
        @(negedge clk);

        // Reset asserted while waiting for the TLB response
        i_req = 1'b1; i_vaddr = 32'h00403ABC; asid = 8'h5A;
        seen = 0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            if (tlb_req) seen = 1;
        end
        chk("rst-wait tlb_req issued", 64'(seen), 64'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst-wait outputs", 64'({i_ack, d_ack, tlb_req, tlb_odd, tlb_vpn2, tlb_asid}), 64'd0);
        chk("rst-wait i_paddr", 64'(i_paddr), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        i_req = 1'b0;
        tlb_rsp_valid = 1'b1; tlb_hit = 1'b1; tlb_pfn = 20'h12345; tlb_v = 1'b1; tlb_c = 3'd3;
        bad = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            tlb_rsp_valid = 1'b0;
            if (i_ack || d_ack || tlb_req) bad = 1;
        end
        chk("rst-wait no late ack", 64'(bad), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
